// File: rtl/led_mode_scheduler.sv
// LED flow-pattern controller: a free-running step tick drives one of four patterns,
// and mode changes from two req/ack ports are deferred to the next step boundary.
module led_mode_scheduler #(
    parameter int TICK_PERIOD = 25000000,
    parameter int LED_W       = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             req_a,
    input  logic [1:0]       mode_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [1:0]       mode_b,
    output logic             ack_b,
    output logic [LED_W-1:0] led,
    output logic [1:0]       cur_mode,
    output logic             busy,
    output logic             step
);

    localparam int CNT_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_PERIOD - 1);

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_FLOW_L = 2'd1;
    localparam logic [1:0] MODE_FLOW_R = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } schedState_e;

    schedState_e      r_state;
    schedState_e      w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;
    logic [LED_W-1:0] r_led;
    logic [LED_W-1:0] w_nextLed;
    logic [1:0]       r_curMode;
    logic [1:0]       w_nextCurMode;
    logic [1:0]       r_pendMode;
    logic [1:0]       w_nextPendMode;
    logic             r_ackA;
    logic             w_nextAckA;
    logic             r_ackB;
    logic             w_nextAckB;
    logic             r_step;
    logic             w_nextStep;

    function automatic logic [LED_W-1:0] loadPattern(input logic [1:0] mode);
        logic [LED_W-1:0] pat;
        case (mode)
            MODE_OFF:    pat = '0;
            MODE_FLOW_L: pat = {{(LED_W-1){1'b0}}, 1'b1};
            MODE_FLOW_R: pat = {1'b1, {(LED_W-1){1'b0}}};
            MODE_BLINK:  pat = '1;
            default:     pat = '0;
        endcase
        return pat;
    endfunction

    function automatic logic [LED_W-1:0] advancePattern(input logic [1:0] mode,
                                                        input logic [LED_W-1:0] cur);
        logic [LED_W-1:0] pat;
        case (mode)
            MODE_OFF:    pat = '0;
            MODE_FLOW_L: pat = {cur[LED_W-2:0], cur[LED_W-1]};
            MODE_FLOW_R: pat = {cur[0], cur[LED_W-1:1]};
            MODE_BLINK:  pat = ~cur;
            default:     pat = cur;
        endcase
        return pat;
    endfunction

    assign w_tick = (r_cnt == CNT_MAX);

    // Free-running divider; mode changes never disturb the step phase.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= ST_RUN;
            r_led      <= {{(LED_W-1){1'b0}}, 1'b1};
            r_curMode  <= MODE_FLOW_L;
            r_pendMode <= MODE_FLOW_L;
            r_ackA     <= 1'b0;
            r_ackB     <= 1'b0;
            r_step     <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_led      <= w_nextLed;
            r_curMode  <= w_nextCurMode;
            r_pendMode <= w_nextPendMode;
            r_ackA     <= w_nextAckA;
            r_ackB     <= w_nextAckB;
            r_step     <= w_nextStep;
        end
    end

    // In RUN a tick and an accept may share one edge: the pattern still advances.
    always_comb begin
        w_nextState    = r_state;
        w_nextLed      = r_led;
        w_nextCurMode  = r_curMode;
        w_nextPendMode = r_pendMode;
        w_nextAckA     = 1'b0;
        w_nextAckB     = 1'b0;
        w_nextStep     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_tick) begin
                    w_nextLed  = advancePattern(r_curMode, r_led);
                    w_nextStep = 1'b1;
                end
                if (req_a) begin
                    w_nextPendMode = mode_a;
                    w_nextAckA     = 1'b1;
                    w_nextState    = ST_PEND;
                end else if (req_b) begin
                    w_nextPendMode = mode_b;
                    w_nextAckB     = 1'b1;
                    w_nextState    = ST_PEND;
                end
            end
            ST_PEND: begin
                if (w_tick) begin
                    w_nextCurMode = r_pendMode;
                    w_nextLed     = loadPattern(r_pendMode);
                    w_nextStep    = 1'b1;
                    w_nextState   = ST_RUN;
                end
            end
            default: begin
                w_nextState = ST_RUN;
            end
        endcase
    end

    assign led      = r_led;
    assign cur_mode = r_curMode;
    assign ack_a    = r_ackA;
    assign ack_b    = r_ackB;
    assign step     = r_step;
    assign busy     = (r_state == ST_PEND);

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Directed bench for led_mode_scheduler with TICK_PERIOD = 4, LED_W = 4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_led_mode_scheduler;

    logic       sys_clk;
    logic       sys_rst;
    logic       req_a;
    logic [1:0] mode_a;
    logic       ack_a;
    logic       req_b;
    logic [1:0] mode_b;
    logic       ack_b;
    logic [3:0] led;
    logic [1:0] cur_mode;
    logic       busy;
    logic       step;

    int checksTotal;
    int checksPassed;

    led_mode_scheduler #(
        .TICK_PERIOD(4),
        .LED_W      (4)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req_a   (req_a),
        .mode_a  (mode_a),
        .ack_a   (ack_a),
        .req_b   (req_b),
        .mode_b  (mode_b),
        .ack_b   (ack_b),
        .led     (led),
        .cur_mode(cur_mode),
        .busy    (busy),
        .step    (step)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checksTotal++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int edges);
        repeat (edges) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic checkState(input string tag, input logic [3:0] expLed,
                              input logic [1:0] expMode, input logic expBusy,
                              input logic expStep);
        checkOutput({tag, ".led"}, 32'(led), 32'(expLed));
        checkOutput({tag, ".mode"}, 32'(cur_mode), 32'(expMode));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(expBusy));
        checkOutput({tag, ".step"}, 32'(step), 32'(expStep));
    endtask

    logic [3:0] flowSeq [4];

    initial begin
        checksTotal  = 0;
        checksPassed = 0;
        sys_rst = 1'b1;
        req_a   = 1'b0;
        mode_a  = 2'd0;
        req_b   = 1'b0;
        mode_b  = 2'd0;
        flowSeq[0] = 4'b0010;
        flowSeq[1] = 4'b0100;
        flowSeq[2] = 4'b1000;
        flowSeq[3] = 4'b0001;

        // Reset values while held in reset
        applyStimulus(2);
        checkState("rst", 4'b0001, 2'd1, 1'b0, 1'b0);
        checkOutput("rst.ack_a", 32'(ack_a), 32'd0);
        checkOutput("rst.ack_b", 32'(ack_b), 32'd0);
        sys_rst = 1'b0;

        // Free run in FLOW_L: one step every 4 edges
        checkState("run0", 4'b0001, 2'd1, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) begin
            applyStimulus(3);
            checkOutput("run.hold", 32'(step), 32'd0);
            applyStimulus(1);
            checkOutput("run.led", 32'(led), 32'(flowSeq[s]));
            checkOutput("run.step", 32'(step), 32'd1);
        end

        // Mid-period port A request for BLINK
        applyStimulus(1);
        req_a  = 1'b1;
        mode_a = 2'd3;
        applyStimulus(1);
        checkOutput("a.ack", 32'(ack_a), 32'd1);
        checkState("a.acc", 4'b0001, 2'd1, 1'b1, 1'b0);
        req_a = 1'b0;
        applyStimulus(1);
        checkOutput("a.ack_end", 32'(ack_a), 32'd0);
        checkOutput("a.busy2", 32'(busy), 32'd1);
        applyStimulus(1);
        checkState("a.apply", 4'b1111, 2'd3, 1'b0, 1'b1);
        applyStimulus(4);
        checkState("a.blink0", 4'b0000, 2'd3, 1'b0, 1'b1);
        applyStimulus(4);
        checkState("a.blink1", 4'b1111, 2'd3, 1'b0, 1'b1);

        // Simultaneous requests: A (FLOW_R) wins, B (OFF) waits for the apply
        req_a  = 1'b1;
        mode_a = 2'd2;
        req_b  = 1'b1;
        mode_b = 2'd0;
        applyStimulus(1);
        checkOutput("ab.ack_a", 32'(ack_a), 32'd1);
        checkOutput("ab.ack_b", 32'(ack_b), 32'd0);
        checkOutput("ab.busy", 32'(busy), 32'd1);
        req_a = 1'b0;
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1);
            checkOutput("ab.wait_ack_b", 32'(ack_b), 32'd0);
            checkOutput("ab.wait_busy", 32'(busy), 32'd1);
        end
        applyStimulus(1);
        checkState("ab.applyA", 4'b1000, 2'd2, 1'b0, 1'b1);
        checkOutput("ab.tick_ack_b", 32'(ack_b), 32'd0);
        applyStimulus(1);
        checkOutput("ab.ack_b2", 32'(ack_b), 32'd1);
        checkState("ab.accB", 4'b1000, 2'd2, 1'b1, 1'b0);
        req_b = 1'b0;
        applyStimulus(3);
        checkState("ab.applyB", 4'b0000, 2'd0, 1'b0, 1'b1);
        applyStimulus(4);
        checkState("ab.offHold", 4'b0000, 2'd0, 1'b0, 1'b1);

        // Back to FLOW_L, then a port B request landing exactly on a tick edge
        req_a  = 1'b1;
        mode_a = 2'd1;
        applyStimulus(1);
        checkOutput("tk.ack_a", 32'(ack_a), 32'd1);
        req_a = 1'b0;
        applyStimulus(3);
        checkState("tk.flowL", 4'b0001, 2'd1, 1'b0, 1'b1);
        applyStimulus(4);
        checkState("tk.pre", 4'b0010, 2'd1, 1'b0, 1'b1);
        applyStimulus(3);
        req_b  = 1'b1;
        mode_b = 2'd2;
        applyStimulus(1);
        checkState("tk.edge", 4'b0100, 2'd1, 1'b1, 1'b1);
        checkOutput("tk.ack_b", 32'(ack_b), 32'd1);
        req_b = 1'b0;
        applyStimulus(3);
        checkState("tk.pend", 4'b0100, 2'd1, 1'b1, 1'b0);
        applyStimulus(1);
        checkState("tk.apply", 4'b1000, 2'd2, 1'b0, 1'b1);

        // Reset while a BLINK change is pending
        req_a  = 1'b1;
        mode_a = 2'd3;
        applyStimulus(1);
        checkOutput("rp.busy", 32'(busy), 32'd1);
        req_a = 1'b0;
        applyStimulus(1);
        sys_rst = 1'b1;
        #1;
        checkState("rp.async", 4'b0001, 2'd1, 1'b0, 1'b0);
        applyStimulus(1);
        sys_rst = 1'b0;
        applyStimulus(3);
        checkState("rp.hold", 4'b0001, 2'd1, 1'b0, 1'b0);
        applyStimulus(1);
        checkState("rp.step", 4'b0010, 2'd1, 1'b0, 1'b1);
        applyStimulus(4);
        checkState("rp.step2", 4'b0100, 2'd1, 1'b0, 1'b1);

        // Re-request of the displayed mode restarts the pattern
        req_a  = 1'b1;
        mode_a = 2'd1;
        applyStimulus(1);
        checkOutput("rr.ack_a", 32'(ack_a), 32'd1);
        req_a = 1'b0;
        applyStimulus(3);
        checkState("rr.apply", 4'b0001, 2'd1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
